// File: rtl/dm_responder.sv
// Data-memory responder: word-addressed RAM behind a one-outstanding request/response
// handshake, answering after a fixed LATENCY with data or a store acknowledge.
module dm_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     mem_q [DEPTH];

  logic            accept;
  logic            req_err;
  logic [AW-1:0]   req_idx;
  logic [31:0]     rd_word;

  assign req_err = (req_addr[1:0] != 2'b00) | ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign req_idx = req_addr[AW+1:2];
  assign accept  = req_valid & req_ready & (state_q == StIdle);

  // With LATENCY == 1 the acceptance edge is also the edge entering RESP, so the
  // array is read with the live request; otherwise with the captured one.
  always_comb begin
    rd_word = '0;
    if (LATENCY == 1) begin
      if (!req_we && !req_err) rd_word = mem_q[req_idx];
    end else begin
      if (!we_q && !err_q) rd_word = mem_q[idx_q];
    end
  end

  // RAM is deliberately outside the reset domain so stores survive a reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem_q[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            we_q      <= req_we;
            err_q     <= req_err;
            idx_q     <= req_idx;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_rdata <= rd_word;
              resp_err   <= req_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q    <= StResp;
            cnt_q      <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= rd_word;
            resp_err   <= err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            state_q    <= StIdle;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (LATENCY 2, 4, 1) share one
// stimulus bus; sel routes req_valid to one instance and muxes its outputs back.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;
  logic [1:0]  sel;

  logic [2:0]  rr_w, rv_w, re_w;
  logic [31:0] rd_w [3];

  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign req_ready  = rr_w[sel];
  assign resp_valid = rv_w[sel];
  assign resp_err   = re_w[sel];
  assign resp_rdata = rd_w[sel];

  dm_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2'd0), .req_ready(rr_w[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv_w[0]), .resp_ready(resp_ready), .resp_rdata(rd_w[0]), .resp_err(re_w[0])
  );

  dm_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2'd1), .req_ready(rr_w[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv_w[1]), .resp_ready(resp_ready), .resp_rdata(rd_w[1]), .resp_err(re_w[1])
  );

  dm_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2'd2), .req_ready(rr_w[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv_w[2]), .resp_ready(resp_ready), .resp_rdata(rd_w[2]), .resp_err(re_w[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on the selected instance; checks latency and return to idle.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int lat,
                     output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", 32'(n), 32'(lat));
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("idle_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        saw;
    logic [31:0] w [4];

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; resp_ready = 1'b0; sel = 2'd0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_rdata", resp_rdata, 32'd0);
      check_eq("rst_err", {31'd0, resp_err}, 32'd0);
    end
    sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic store/load, LATENCY 2
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, rd, er);
    check_eq("st_rdata", rd, 32'd0);
    check_eq("st_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 2, rd, er);
    check_eq("ld_rdata", rd, 32'hDEADBEEF);
    check_eq("ld_err", {31'd0, er}, 32'd0);

    // Byte-enable merge
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 2, rd, er);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2, rd, er);
    txn(1'b0, 32'h20, 32'h0, 4'hF, 2, rd, er);
    check_eq("be_merge", rd, 32'h11BB33DD);

    // be = 0 store writes nothing but still responds normally
    txn(1'b1, 32'h10, 32'h12345678, 4'h0, 2, rd, er);
    check_eq("be0_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 2, rd, er);
    check_eq("be0_unchanged", rd, 32'hDEADBEEF);

    // Errors
    txn(1'b1, 32'h0, 32'h01020304, 4'hF, 2, rd, er);
    txn(1'b0, 32'h402, 32'h0, 4'h0, 2, rd, er);
    check_eq("err_ld_err", {31'd0, er}, 32'd1);
    check_eq("err_ld_rdata", rd, 32'd0);
    txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 2, rd, er);
    check_eq("err_st_err", {31'd0, er}, 32'd1);
    check_eq("err_st_rdata", rd, 32'd0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 2, rd, er);
    check_eq("oor_st_no_write", rd, 32'h01020304);
    txn(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 2, rd, er);
    check_eq("misal_st_err", {31'd0, er}, 32'd1);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 2, rd, er);
    check_eq("misal_st_no_write", rd, 32'hDEADBEEF);

    // Backpressure
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_first_valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("bp_rdata", resp_rdata, 32'hDEADBEEF);
      check_eq("bp_err", {31'd0, resp_err}, 32'd0);
      check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("bp_release_ready", {31'd0, req_ready}, 32'd1);
    check_eq("bp_release_valid", {31'd0, resp_valid}, 32'd0);

    // Async reset during WAIT, LATENCY 4
    sel = 2'd1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check_eq("mid_rst_no_resp", {31'd0, saw}, 32'd0);
    txn(1'b0, 32'h30, 32'h0, 4'h0, 4, rd, er);
    check_eq("rst_store_kept", rd, 32'h5A5A5A5A);

    // LATENCY 1 back-to-back loads
    sel = 2'd2;
    for (int k = 0; k < 4; k++) begin
      w[k] = 32'hC0DE0000 | 32'(k * 17);
      txn(1'b1, 32'h40 + 32'(4 * k), w[k], 4'hF, 1, rd, er);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("b2b_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("b2b_rdata", resp_rdata, w[k]);
      check_eq("b2b_busy", {31'd0, req_ready}, 32'd0);
      if (k == 3) req_valid = 1'b0;
      else req_addr = 32'h40 + 32'(4 * (k + 1));
      @(negedge clk);
      check_eq("b2b_gap_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("b2b_gap_ready", {31'd0, req_ready}, 32'd1);
    end
    resp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
